// File: rtl/rom_loader.sv
// rom_loader: copies a byte stream from a valid/ready source onto a memory
// initialisation bus at consecutive addresses starting from a sampled base.
// A source that stalls too long in FETCH raises err; abort cancels a load.
// Optional build macro ROM_LOADER_CHECKSUM_EN adds a trailing 8-bit
// additive checksum byte that is compared in a CHECK state.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start, nothing loaded
// FETCH | waiting for the next source byte (sReady=1), timeout runs
// WRITE | one-cycle iniWr pulse of the byte taken in FETCH
// CHECK | waiting for the trailing checksum byte (macro builds only)
// DONE  | load finished, done=1 until next accepted start
// ERR   | timeout or checksum mismatch, err=1 until next accepted start
module rom_loader #(
    parameter int TMO = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] base,
    input  logic [15:0] len,
    input  logic        sValid,
    input  logic [7:0]  sD,
    output logic        sReady,
    output logic        iniBusy,
    output logic        iniWr,
    output logic [15:0] iniA,
    output logic [7:0]  iniD,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
`ifdef ROM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd3;
`endif
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    // Timeout counter only ever holds 0..TMO-1.
    localparam int TW = (TMO < 2) ? 1 : $clog2(TMO);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    logic [2:0]    state;
    logic [15:0]   base_q;
    logic [16:0]   len_q;
    logic [16:0]   count;
    logic [TW-1:0] tmo_cnt;
    logic [16:0]   count_inc;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]    sum;
`endif

    assign count_inc = count + 17'd1;

    // Status and handshake outputs decode straight from state so an
    // asynchronous reset clears them without waiting for a clock edge.
    always_comb begin
        iniWr   = (state == S_WRITE);
        done    = (state == S_DONE);
        err     = (state == S_ERR);
`ifdef ROM_LOADER_CHECKSUM_EN
        sReady  = (state == S_FETCH) || (state == S_CHECK);
        iniBusy = (state == S_FETCH) || (state == S_WRITE) || (state == S_CHECK);
`else
        sReady  = (state == S_FETCH);
        iniBusy = (state == S_FETCH) || (state == S_WRITE);
`endif
    end

    // Sequencer: state, latched job parameters, counters and the write bus.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            count   <= '0;
            tmo_cnt <= '0;
            iniA    <= '0;
            iniD    <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        base_q  <= base;
                        len_q   <= {1'b0, len};
                        count   <= '0;
                        tmo_cnt <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                        sum     <= '0;
`endif
                        state   <= (len == 16'd0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (sValid) begin
                        // Address/data are registered at the take so they
                        // are valid during WRITE and hold afterwards.
                        iniA    <= base_q + count[15:0];
                        iniD    <= sD;
                        tmo_cnt <= '0;
                        state   <= S_WRITE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= S_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        count   <= count_inc;
                        tmo_cnt <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                        sum     <= sum + iniD;
                        state   <= (count_inc == len_q) ? S_CHECK : S_FETCH;
`else
                        state   <= (count_inc == len_q) ? S_DONE : S_FETCH;
`endif
                    end
                end
`ifdef ROM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (sValid) begin
                        state <= (sD == sum) ? S_DONE : S_ERR;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= S_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: expected writes go into a queue as bytes are sent;
// a negedge monitor pops and compares whenever iniWr is seen.
module tb_rom_loader;

    localparam int TMO = 16;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] base;
    logic [15:0] len;
    logic        sValid;
    logic [7:0]  sD;
    logic        sReady;
    logic        iniBusy;
    logic        iniWr;
    logic [15:0] iniA;
    logic [7:0]  iniD;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;
    int wr_seen = 0;
    logic [23:0] exp_q[$];

    rom_loader #(.TMO(TMO)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .base(base), .len(len), .sValid(sValid), .sD(sD), .sReady(sReady),
        .iniBusy(iniBusy), .iniWr(iniWr), .iniA(iniA), .iniD(iniD),
        .done(done), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every write must match the oldest expected (address, data).
    always @(negedge clock) begin
        if (reset && iniWr) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got A=%h D=%h expected none", iniA, iniD);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                chk("write_addr", {16'h0, iniA}, {16'h0, e[23:8]});
                chk("write_data", {24'h0, iniD}, {24'h0, e[7:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_load(input logic [15:0] b, input logic [15:0] l);
        base  = b;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer one byte; if push is set, expect it written at addr.
    task automatic send_byte(input logic [7:0] b, input logic [15:0] addr, input bit push);
        int n = 0;
        sValid = 1'b1;
        sD     = b;
        while (!sReady && n < 50) begin
            tick();
            n++;
        end
        if (!sReady) begin
            chk("sready_timeout", 32'(sReady), 32'd1);
            sValid = 1'b0;
        end else begin
            if (push) exp_q.push_back({addr, b});
            tick();
            sValid = 1'b0;
            if (push) chk("take_to_wr_latency", 32'(iniWr), 32'd1);
        end
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || err) && n < 4 * TMO) begin
            tick();
            n++;
        end
        if (!(done || err)) chk("end_timeout", 32'(done | err), 32'd1);
    endtask

    initial begin
        int w0;
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        base = '0; len = '0; sValid = 1'b0; sD = '0;
        #3;
        chk("rst_busy",  32'(iniBusy), 0);
        chk("rst_wr",    32'(iniWr), 0);
        chk("rst_ready", 32'(sReady), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_err",   32'(err), 0);
        chk("rst_addr",  32'(iniA), 0);
        chk("rst_data",  32'(iniD), 0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Back-to-back load of four bytes from 0000.
        start_load(16'h0000, 16'd4);
        chk("busy_in_fetch",  32'(iniBusy), 1);
        chk("ready_in_fetch", 32'(sReady), 1);
        send_byte(8'h11, 16'h0000, 1);
        send_byte(8'h22, 16'h0001, 1);
        send_byte(8'h33, 16'h0002, 1);
        send_byte(8'h44, 16'h0003, 1);
        wait_end();
        chk("b2b_done", 32'(done), 1);
        chk("b2b_err",  32'(err), 0);
        chk("b2b_busy", 32'(iniBusy), 0);
        tick();
        chk("hold_addr", 32'(iniA), 32'h0003);
        chk("hold_data", 32'(iniD), 32'h44);
        chk("done_holds", 32'(done), 1);

        // Address wrap FFFF -> 0000.
        start_load(16'hFFFE, 16'd3);
        chk("done_cleared", 32'(done), 0);
        send_byte(8'hA1, 16'hFFFE, 1);
        send_byte(8'hB2, 16'hFFFF, 1);
        send_byte(8'hC3, 16'h0000, 1);
        wait_end();
        chk("wrap_done", 32'(done), 1);

        // len=0 finishes with no write.
        w0 = wr_seen;
        start_load(16'h1234, 16'd0);
        chk("len0_done", 32'(done), 1);
        chk("len0_busy", 32'(iniBusy), 0);
        tick(); tick();
        chk("len0_nowr", 32'(wr_seen - w0), 0);

        // Stall after the first byte: timeout after exactly TMO FETCH cycles.
        w0 = wr_seen;
        start_load(16'h0100, 16'd2);
        send_byte(8'h5A, 16'h0100, 1);
        repeat (TMO) tick();
        chk("tmo_not_early", 32'(err), 0);
        tick();
        chk("tmo_err",   32'(err), 1);
        chk("tmo_busy",  32'(iniBusy), 0);
        chk("tmo_done",  32'(done), 0);
        chk("tmo_one_wr", 32'(wr_seen - w0), 1);

        // Start while busy is ignored; abort beats the take of byte 3.
        w0 = wr_seen;
        start_load(16'h0200, 16'd5);
        chk("err_cleared", 32'(err), 0);
        send_byte(8'h01, 16'h0200, 1);
        start_load(16'h9000, 16'd1);
        send_byte(8'h02, 16'h0201, 1);
        tick();
        chk("abort_ready", 32'(sReady), 1);
        sValid = 1'b1; sD = 8'h77; abort = 1'b1;
        tick();
        sValid = 1'b0; abort = 1'b0;
        chk("abort_busy",  32'(iniBusy), 0);
        chk("abort_done",  32'(done), 0);
        chk("abort_err",   32'(err), 0);
        repeat (4) tick();
        chk("abort_no_wr", 32'(wr_seen - w0), 2);

`ifdef ROM_LOADER_CHECKSUM_EN
        // Trailing checksum byte: good then bad.
        start_load(16'h0400, 16'd2);
        send_byte(8'h10, 16'h0400, 1);
        send_byte(8'h20, 16'h0401, 1);
        send_byte(8'h30, 16'h0000, 0);
        wait_end();
        chk("csum_ok_done", 32'(done), 1);
        chk("csum_ok_err",  32'(err), 0);
        start_load(16'h0400, 16'd2);
        send_byte(8'h10, 16'h0400, 1);
        send_byte(8'h20, 16'h0401, 1);
        send_byte(8'h31, 16'h0000, 0);
        wait_end();
        chk("csum_bad_err",  32'(err), 1);
        chk("csum_bad_done", 32'(done), 0);
`endif

        // Reset during WRITE clears outputs without a clock edge.
        start_load(16'h0300, 16'd3);
        send_byte(8'hEE, 16'h0000, 0);
        chk("pre_rst_wr", 32'(iniWr), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_wr",   32'(iniWr), 0);
        chk("async_rst_busy", 32'(iniBusy), 0);
        chk("async_rst_addr", 32'(iniA), 0);
        chk("async_rst_data", 32'(iniD), 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("post_rst_done", 32'(done), 0);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter TMO, default 1023: number of FETCH cycles without a source byte before an error is flagged.
REQ-002 SHALL have port clock, input, 1: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: one-cycle request to begin a load.
REQ-005 SHALL have port abort, input, 1: cancels a load in progress.
REQ-006 SHALL have port base, input, 16: first target address, sampled on accepted start.
REQ-007 SHALL have port len, input, 16: byte count, sampled on accepted start; 0 means no bytes.
REQ-008 SHALL have ports sValid (input, 1), sD (input, 8) and sReady (output, 1): byte-stream source handshake.
REQ-009 SHALL have ports iniBusy (output, 1), iniWr (output, 1), iniA (output, 16) and iniD (output, 8): memory initialisation bus.
REQ-010 SHALL have ports done (output, 1) and err (output, 1): status levels.

Function
REQ-011 SHALL implement the states IDLE, FETCH, WRITE, CHECK, DONE and ERR.
REQ-012 SHALL accept start only in IDLE, DONE or ERR; start in any other state SHALL be ignored.
REQ-013 On accepted start: latch base and len, clear the byte count, clear done and err, then go to FETCH; if len==0, go straight to DONE with no write.
REQ-014 sReady SHALL be 1 only in FETCH; a byte is taken in a cycle where sValid && sReady, and sD is latched in that cycle.
REQ-015 The state after a take SHALL be WRITE; in WRITE, iniWr=1 for exactly one cycle, iniA=base+count (mod 2^16, wraps FFFF->0000), iniD=latched byte.
REQ-016 After WRITE, count SHALL increment; if count reaches len, go to CHECK (macro on) or DONE (macro off); otherwise go back to FETCH.
REQ-017 Throughput SHALL be at most one byte per 2 cycles; the take-to-iniWr latency SHALL be 1 cycle.
REQ-018 iniBusy SHALL be 1 in FETCH, WRITE and CHECK, and 0 otherwise; iniA and iniD SHALL hold their last values while iniWr=0.
REQ-019 A timeout counter SHALL clear on every take and on entering FETCH; after TMO consecutive FETCH cycles with sValid=0, go to ERR.
REQ-020 abort in any busy state SHALL go to IDLE next cycle with no further iniWr; abort has priority over a take and over a timeout in the same cycle.
REQ-021 done SHALL be 1 in DONE and err SHALL be 1 in ERR; both hold until the next accepted start or reset.
REQ-022 The len counter SHALL be 17 bits wide so that len=FFFF completes without overflow.

Reset
REQ-023 reset=0 SHALL immediately force IDLE, with iniBusy=iniWr=sReady=done=err=0, iniA=0, iniD=0 and all counters at 0.
REQ-024 A reset during a load SHALL abandon it; no partial-state recovery.

Configuration
REQ-025 Macro ROM_LOADER_CHECKSUM_EN, when defined: keep an 8-bit additive sum of the written bytes; CHECK has sReady=1, takes one trailing byte and issues no write; if the byte equals the sum, go to DONE, otherwise go to ERR; the timeout also applies in CHECK.
REQ-026 Without the macro: the CHECK state, the sum register and the trailing byte are absent, and the last WRITE goes to DONE.

Verification
REQ-027 base=0000, len=4, bytes 11 22 33 44 supplied back-to-back -> iniWr pulses at A=0000..0003 with D=11..44, iniBusy falls, then done=1.
REQ-028 base=FFFE, len=3 -> writes at FFFE, FFFF, 0000, then done=1.
REQ-029 len=2, source stalls after byte 1 for TMO cycles -> err=1, iniBusy=0, exactly one iniWr seen.
REQ-030 abort asserted on the same cycle as a take of the 3rd byte -> IDLE, no 3rd iniWr, done=0.
REQ-031 With the macro: len=2, bytes 10 20, trailer 30 -> done=1; trailer 31 -> err=1.
REQ-032 reset pulled low during WRITE -> iniWr=0 and iniBusy=0 without waiting for a clock edge; start pulses while busy have no effect.
